// File: rtl/reg_arith_pkg.sv
// Shared types for the pipelined register arithmetic unit.
// The optional clamping behaviour is enabled by defining REG_ARITH_SATURATE_EN.
package reg_arith_pkg;

    typedef enum logic [2:0] {
        OP_INCR = 3'd0,
        OP_DECR = 3'd1,
        OP_JIZR = 3'd2,
        OP_JNZR = 3'd3,
        OP_ADDV = 3'd4,
        OP_SUBV = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Width of the shifted offset before zero-extension to the datapath width.
    function automatic int off_width(input int vw, input int shift);
        return vw + shift;
    endfunction

    // Width-independent control half of the S1 register; the W-bit operands
    // are added around it inside the top module.
    typedef struct packed {
        op_e  op;
        logic cin;
        logic taken;
        logic err;
        logic sub;
    } s1_ctrl_t;

endpackage

// File: rtl/reg_arith_adder.sv
// Combinational W-bit ripple-carry adder: s = x + y + cin.
module reg_arith_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic c;

    // Ripple the carry bit by bit, LSB first.
    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/reg_arith_pipe.sv
// Two-stage valid/ready register/PC arithmetic pipeline.
// S1 decodes the op and prepares the adder operands; S2 adds and flags.
// Define REG_ARITH_SATURATE_EN to clamp INCR/ADDV overflow and DECR/SUBV underflow.
module reg_arith_pipe
    import reg_arith_pkg::*;
#(
    parameter int W     = 8,
    parameter int VW    = 3,
    parameter int SHIFT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [W-1:0]  in_x,
    input  logic [VW-1:0] in_v,
    input  logic          in_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_res,
    output logic          out_carry,
    output logic          out_zero,
    output logic          out_taken,
    output logic          out_err
);

    localparam int OFF_W = off_width(VW, SHIFT);

`ifdef REG_ARITH_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        s1_ctrl_t     ctrl;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } s1_t;

    op_e          op;
    logic [OFF_W-1:0] off_n;
    logic [W-1:0] off;
    s1_t          s1_d, s1_q;
    logic         s1_valid, s1_ready, s2_ready;
    logic [W-1:0] sum, res_d;
    logic         cout, carry_d, is_add;

    assign op       = op_e'(in_op);
    assign off_n    = OFF_W'(in_v) << SHIFT;
    assign off      = W'(off_n);
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Decode: pick the second adder operand, pre-inverted with cin=1 for subtracts.
    always_comb begin
        s1_d         = '0;
        s1_d.x       = in_x;
        s1_d.ctrl.op = op;
        case (op)
            OP_INCR: s1_d.y = W'(1);
            OP_DECR: begin
                s1_d.y        = ~W'(1);
                s1_d.ctrl.cin = 1'b1;
                s1_d.ctrl.sub = 1'b1;
            end
            OP_JIZR, OP_JNZR: begin
                s1_d.ctrl.taken = (op == OP_JIZR) ? in_z : !in_z;
                s1_d.y          = s1_d.ctrl.taken ? off : W'(1);
            end
            OP_ADDV: s1_d.y = off;
            OP_SUBV: begin
                s1_d.y        = ~off;
                s1_d.ctrl.cin = 1'b1;
                s1_d.ctrl.sub = 1'b1;
            end
            default: s1_d.ctrl.err = 1'b1;  // y=0, cin=0 passes x through
        endcase
    end

    // S1 register: load whenever it is empty or draining into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    reg_arith_adder #(.W(W)) u_adder (
        .x    (s1_q.x),
        .y    (s1_q.y),
        .cin  (s1_q.ctrl.cin),
        .s    (sum),
        .cout (cout)
    );

    // Carry/borrow reporting and optional clamp; jumps never clamp.
    always_comb begin
        is_add  = (s1_q.ctrl.op == OP_INCR) || (s1_q.ctrl.op == OP_ADDV);
        carry_d = s1_q.ctrl.err ? 1'b0 : (s1_q.ctrl.sub ? !cout : cout);
        res_d   = sum;
        if (SAT_EN && is_add && cout)
            res_d = '1;
        else if (SAT_EN && s1_q.ctrl.sub && !cout)
            res_d = '0;
    end

    // S2 register: holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_taken <= 1'b0;
            out_err   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res   <= res_d;
                out_carry <= carry_d;
                out_zero  <= (res_d == '0);
                out_taken <= s1_q.ctrl.taken;
                out_err   <= s1_q.ctrl.err;
            end
        end
    end

endmodule
